// File: rtl/spif_pkt_pkg.sv
// Shared packet definitions for the SpiNNaker link: field offsets, source ids,
// odd-parity helper and peripheral packet assembly.
package spif_pkt_pkg;

  localparam int PKT_BITS    = 72;
  localparam int KEY_BITS    = 32;
  localparam int PLD_BITS    = 32;
  localparam int PKT_PAR_BIT = 0;
  localparam int PKT_LNG_BIT = 1;
  localparam int PKT_KEY_BIT = 8;
  localparam int PKT_PLD_BIT = 40;

  typedef enum logic {
    SRC_PER = 1'b0,
    SRC_DCP = 1'b1
  } src_t;

  // Parity bit that makes the popcount of the whole packet odd.
  function automatic logic pkt_parity(input logic [PKT_BITS-1:0] pkt);
    return ~(^pkt[PKT_BITS-1:1]);
  endfunction

  function automatic logic [PKT_BITS-1:0] pkt_build(
    input logic [KEY_BITS-1:0] key,
    input logic [PLD_BITS-1:0] pld,
    input logic                lng
  );
    logic [PKT_BITS-1:0] p;
    p = '0;
    p[PKT_KEY_BIT +: KEY_BITS] = key;
    if (lng) p[PKT_PLD_BIT +: PLD_BITS] = pld;
    p[PKT_LNG_BIT] = lng;
    p[PKT_PAR_BIT] = pkt_parity(p);
    return p;
  endfunction

endpackage

// File: rtl/pkt_tx_arbiter.sv
// Two-input round-robin arbiter (PER vs DCP) with a one-bit last-grant pointer.
// Grant is combinational; the pointer only moves when a grant is taken (adv_i).
module pkt_tx_arbiter
  import spif_pkt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic per_req_i,
  input  logic dcp_req_i,
  input  logic adv_i,
  output logic gnt_vld_o,
  output src_t gnt_o
);

  src_t last_q, last_d;

  always_comb begin
    gnt_vld_o = per_req_i || dcp_req_i;
    gnt_o     = SRC_PER;
    if (per_req_i && dcp_req_i) begin
      gnt_o = (last_q == SRC_PER) ? SRC_DCP : SRC_PER;
    end else if (dcp_req_i) begin
      gnt_o = SRC_DCP;
    end
  end

  always_comb begin
    last_d = last_q;
    if (adv_i && gnt_vld_o) last_d = gnt_o;
  end

  // Reset to DCP so the first contested grant goes to the peripheral side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SRC_DCP;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/pkt_transmitter.sv
// Merges peripheral events and diagnostic replies into one packet stream; 1-cycle latency.
// Single output register; peripheral traffic is shed after drop_wait_in stalled cycles.
module pkt_transmitter
  import spif_pkt_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [KEY_BITS-1:0] per_key_in,
  input  logic [PLD_BITS-1:0] per_pld_in,
  input  logic                per_lng_in,
  input  logic                per_vld_in,
  output logic                per_rdy_out,
  input  logic [PKT_BITS-1:0] dcp_data_in,
  input  logic                dcp_vld_in,
  output logic                dcp_rdy_out,
  input  logic [31:0]         drop_wait_in,
  output logic [PKT_BITS-1:0] pkt_data_out,
  output logic                pkt_vld_out,
  input  logic                pkt_rdy_in,
  output logic [2:0]          ptx_cnt_out
);

  logic [PKT_BITS-1:0] data_q, data_d;
  logic                vld_q, vld_d;
  src_t                src_q, src_d;
  logic [31:0]         stall_q, stall_d;

  logic                load;
  logic                xfer;
  logic                gnt_vld;
  src_t                gnt;
  logic                per_gnt;
  logic                dcp_gnt;
  logic                drop_act;
  logic [PKT_BITS-1:0] per_pkt;

  assign per_pkt = pkt_build(per_key_in, per_pld_in, per_lng_in);
  assign load    = !vld_q || pkt_rdy_in;
  assign xfer    = vld_q && pkt_rdy_in;

  pkt_tx_arbiter u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .per_req_i (per_vld_in),
    .dcp_req_i (dcp_vld_in),
    .adv_i     (load),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  assign per_gnt = load && gnt_vld && (gnt == SRC_PER);
  assign dcp_gnt = load && gnt_vld && (gnt == SRC_DCP);

  // A cycle that transfers (load=1) always grants normally instead of dropping.
  assign drop_act = (drop_wait_in != 32'd0) && (stall_q >= drop_wait_in) && !load;

  assign per_rdy_out = reset_n && (per_gnt || drop_act);
  assign dcp_rdy_out = reset_n && dcp_gnt;

  assign ptx_cnt_out = {drop_act && per_vld_in,
                        xfer && (src_q == SRC_DCP),
                        xfer && (src_q == SRC_PER)};

  assign pkt_data_out = data_q;
  assign pkt_vld_out  = vld_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    src_d  = src_q;
    if (load) begin
      vld_d = gnt_vld;
      if (gnt_vld) begin
        src_d  = gnt;
        data_d = (gnt == SRC_PER) ? per_pkt : dcp_data_in;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!vld_q || pkt_rdy_in) begin
      stall_d = 32'd0;
    end else if (stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      vld_q   <= 1'b0;
      src_q   <= SRC_PER;
      stall_q <= 32'd0;
    end else begin
      data_q  <= data_d;
      vld_q   <= vld_d;
      src_q   <= src_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pkt_transmitter.sv
// Directed self-checking bench for pkt_transmitter; inputs driven 1ns after
// posedge, outputs sampled on negedge.
module tb_pkt_transmitter;

  logic        clk;
  logic        reset_n;
  logic [31:0] per_key_in;
  logic [31:0] per_pld_in;
  logic        per_lng_in;
  logic        per_vld_in;
  logic        per_rdy_out;
  logic [71:0] dcp_data_in;
  logic        dcp_vld_in;
  logic        dcp_rdy_out;
  logic [31:0] drop_wait_in;
  logic [71:0] pkt_data_out;
  logic        pkt_vld_out;
  logic        pkt_rdy_in;
  logic [2:0]  ptx_cnt_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  localparam logic [71:0] DCP_PKT = 72'hA5_1122_3344_5566_7788;

  pkt_transmitter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .per_key_in   (per_key_in),
    .per_pld_in   (per_pld_in),
    .per_lng_in   (per_lng_in),
    .per_vld_in   (per_vld_in),
    .per_rdy_out  (per_rdy_out),
    .dcp_data_in  (dcp_data_in),
    .dcp_vld_in   (dcp_vld_in),
    .dcp_rdy_out  (dcp_rdy_out),
    .drop_wait_in (drop_wait_in),
    .pkt_data_out (pkt_data_out),
    .pkt_vld_out  (pkt_vld_out),
    .pkt_rdy_in   (pkt_rdy_in),
    .ptx_cnt_out  (ptx_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    per_key_in   = '0;
    per_pld_in   = '0;
    per_lng_in   = 1'b0;
    per_vld_in   = 1'b0;
    dcp_data_in  = '0;
    dcp_vld_in   = 1'b0;
    drop_wait_in = '0;
    pkt_rdy_in   = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    per_vld_in = 1'b1;
    dcp_vld_in = 1'b1;
    reset_n    = 1'b0;
    cyc();
    @(negedge clk);
    chk_cnt++; if (pkt_vld_out !== 1'b0) $display("FAIL rst_vld got %b exp 0", pkt_vld_out); else pass_cnt++;
    chk_cnt++; if (pkt_data_out !== 72'h0) $display("FAIL rst_data got %h exp 0", pkt_data_out); else pass_cnt++;
    chk_cnt++; if (ptx_cnt_out !== 3'b000) $display("FAIL rst_cnt got %b exp 000", ptx_cnt_out); else pass_cnt++;
    chk_cnt++; if (per_rdy_out !== 1'b0) $display("FAIL rst_per_rdy got %b exp 0", per_rdy_out); else pass_cnt++;
    chk_cnt++; if (dcp_rdy_out !== 1'b0) $display("FAIL rst_dcp_rdy got %b exp 0", dcp_rdy_out); else pass_cnt++;
    do_reset();
  endtask

  // Sends one peripheral packet with pkt_rdy_in=1 and checks accept, data and counter pulse.
  task automatic test_per_pkt(input string nm, input logic [31:0] key, input logic [31:0] pld,
                              input logic lng, input logic [71:0] exp_pkt);
    per_key_in = key;
    per_pld_in = pld;
    per_lng_in = lng;
    per_vld_in = 1'b1;
    @(negedge clk);
    chk_cnt++; if (per_rdy_out !== 1'b1) $display("FAIL %s_rdy got %b exp 1", nm, per_rdy_out); else pass_cnt++;
    cyc();
    per_vld_in = 1'b0;
    @(negedge clk);
    chk_cnt++; if (pkt_vld_out !== 1'b1) $display("FAIL %s_vld got %b exp 1", nm, pkt_vld_out); else pass_cnt++;
    chk_cnt++; if (pkt_data_out !== exp_pkt) $display("FAIL %s_data got %h exp %h", nm, pkt_data_out, exp_pkt); else pass_cnt++;
    chk_cnt++; if (ptx_cnt_out !== 3'b001) $display("FAIL %s_cnt got %b exp 001", nm, ptx_cnt_out); else pass_cnt++;
    cyc();
    @(negedge clk);
    chk_cnt++; if (pkt_vld_out !== 1'b0) $display("FAIL %s_idle got %b exp 0", nm, pkt_vld_out); else pass_cnt++;
    cyc();
  endtask

  task automatic test_dcp();
    dcp_data_in = DCP_PKT;
    dcp_vld_in  = 1'b1;
    @(negedge clk);
    chk_cnt++; if (dcp_rdy_out !== 1'b1) $display("FAIL dcp_rdy got %b exp 1", dcp_rdy_out); else pass_cnt++;
    cyc();
    dcp_vld_in = 1'b0;
    @(negedge clk);
    chk_cnt++; if (pkt_data_out !== DCP_PKT) $display("FAIL dcp_data got %h exp %h", pkt_data_out, DCP_PKT); else pass_cnt++;
    chk_cnt++; if (ptx_cnt_out !== 3'b010) $display("FAIL dcp_cnt got %b exp 010", ptx_cnt_out); else pass_cnt++;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [71:0] per_exp;
    per_exp = {32'h0, 32'hAAAA_0000, 8'h01};
    do_reset();
    per_key_in  = 32'hAAAA_0000;
    per_vld_in  = 1'b1;
    dcp_data_in = DCP_PKT;
    dcp_vld_in  = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({per_rdy_out, dcp_rdy_out} !== 2'b10) $display("FAIL rr_first got %b exp 10", {per_rdy_out, dcp_rdy_out}); else pass_cnt++;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      @(negedge clk);
      if (k % 2 == 1) begin
        chk_cnt++; if (ptx_cnt_out !== 3'b001 || pkt_data_out !== per_exp)
          $display("FAIL rr_%0d got cnt %b data %h exp cnt 001 data %h", k, ptx_cnt_out, pkt_data_out, per_exp);
        else pass_cnt++;
      end else begin
        chk_cnt++; if (ptx_cnt_out !== 3'b010 || pkt_data_out !== DCP_PKT)
          $display("FAIL rr_%0d got cnt %b data %h exp cnt 010 data %h", k, ptx_cnt_out, pkt_data_out, DCP_PKT);
        else pass_cnt++;
      end
    end
    per_vld_in = 1'b0;
    dcp_vld_in = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_drop();
    logic [71:0] held;
    int bad;
    held = {32'h0, 32'h0000_0055, 8'h01};
    do_reset();
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 32'd10;
    per_key_in   = 32'h0000_0055;
    per_vld_in   = 1'b1;
    @(negedge clk);
    chk_cnt++; if (per_rdy_out !== 1'b1) $display("FAIL drop_cap_rdy got %b exp 1", per_rdy_out); else pass_cnt++;
    cyc();
    per_key_in  = 32'h0000_0077;
    dcp_data_in = DCP_PKT;
    dcp_vld_in  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (per_rdy_out !== 1'b0 || dcp_rdy_out !== 1'b0 || ptx_cnt_out !== 3'b000 ||
          pkt_data_out !== held || pkt_vld_out !== 1'b1) bad++;
      cyc();
    end
    chk_cnt++; if (bad != 0) $display("FAIL drop_wait got %0d bad cycles exp 0", bad); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (per_rdy_out !== 1'b1 || dcp_rdy_out !== 1'b0 || ptx_cnt_out !== 3'b100 ||
          pkt_data_out !== held || pkt_vld_out !== 1'b1) bad++;
      cyc();
    end
    chk_cnt++; if (bad != 0) $display("FAIL drop_active got %0d bad cycles exp 0", bad); else pass_cnt++;
    drop_wait_in = 32'd0;
    @(negedge clk);
    chk_cnt++; if ({per_rdy_out, ptx_cnt_out[2]} !== 2'b00) $display("FAIL drop_disable got %b exp 00", {per_rdy_out, ptx_cnt_out[2]}); else pass_cnt++;
    cyc();
    drop_wait_in = 32'd10;
    pkt_rdy_in   = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({per_rdy_out, dcp_rdy_out, ptx_cnt_out} !== 5'b01_001)
      $display("FAIL drop_release got %b exp 01001", {per_rdy_out, dcp_rdy_out, ptx_cnt_out}); else pass_cnt++;
    cyc();
    @(negedge clk);
    chk_cnt++; if (pkt_data_out !== DCP_PKT || ptx_cnt_out !== 3'b010 || per_rdy_out !== 1'b1)
      $display("FAIL drop_after got data %h cnt %b rdy %b exp %h 010 1", pkt_data_out, ptx_cnt_out, per_rdy_out, DCP_PKT);
    else pass_cnt++;
    per_vld_in = 1'b0;
    dcp_vld_in = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_no_drop();
    logic [71:0] held;
    int bad;
    held = {32'h0, 32'h0000_0055, 8'h01};
    do_reset();
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 32'd0;
    per_key_in   = 32'h0000_0055;
    per_vld_in   = 1'b1;
    cyc();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (per_rdy_out !== 1'b0 || ptx_cnt_out !== 3'b000 || pkt_data_out !== held) bad++;
      cyc();
    end
    chk_cnt++; if (bad != 0) $display("FAIL nodrop got %0d bad cycles exp 0", bad); else pass_cnt++;
    per_vld_in = 1'b0;
    pkt_rdy_in = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [71:0] per_exp;
    per_exp = {32'h0, 32'h0000_0001, 8'h00};
    do_reset();
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 32'd3;
    per_key_in   = 32'h0000_0055;
    per_vld_in   = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    #1;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if ({pkt_vld_out, ptx_cnt_out, per_rdy_out} !== 5'b0_000_0)
      $display("FAIL midrst got %b exp 00000", {pkt_vld_out, ptx_cnt_out, per_rdy_out}); else pass_cnt++;
    cyc();
    reset_n     = 1'b1;
    per_key_in  = 32'h0000_0001;
    dcp_data_in = DCP_PKT;
    dcp_vld_in  = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({per_rdy_out, dcp_rdy_out} !== 2'b10) $display("FAIL midrst_tie got %b exp 10", {per_rdy_out, dcp_rdy_out}); else pass_cnt++;
    cyc();
    @(negedge clk);
    chk_cnt++; if (pkt_data_out !== per_exp || per_rdy_out !== 1'b0 || ptx_cnt_out !== 3'b000)
      $display("FAIL midrst_stall got data %h rdy %b cnt %b exp %h 0 000", pkt_data_out, per_rdy_out, ptx_cnt_out, per_exp);
    else pass_cnt++;
    per_vld_in = 1'b0;
    dcp_vld_in = 1'b0;
    pkt_rdy_in = 1'b1;
    cyc();
    cyc();
  endtask

  initial begin
    test_reset();
    test_per_pkt("short", 32'h0000_0001, 32'h0, 1'b0, {32'h0, 32'h0000_0001, 8'h00});
    test_per_pkt("long", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFF, 32'h1234_5678, 8'h03});
    test_per_pkt("short_pld", 32'h0000_0003, 32'hDEAD_BEEF, 1'b0, {32'h0, 32'h0000_0003, 8'h01});
    test_dcp();
    test_round_robin();
    test_drop();
    test_no_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
